// File: rtl/ask4_pkg.sv
// Shared types and default timing constants for the 4-level ASK receive path.
package ask4_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK
  } state_t;

  localparam int unsigned HP0_DEF     = 4;
  localparam int unsigned HP1_DEF     = 8;
  localparam int unsigned HP2_DEF     = 16;
  localparam int unsigned HP3_DEF     = 32;
  localparam int unsigned TOL_DEF     = 1;
  localparam int unsigned CONFIRM_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 8;

  // True when meas lies within hp +/- tol (written to avoid unsigned underflow).
  function automatic logic in_tol(input int unsigned meas, input int unsigned hp,
                                  input int unsigned tol);
    return ((meas + tol) >= hp) && (meas <= (hp + tol));
  endfunction

endpackage

// File: rtl/ask4_edge_sync.sv
// Two-flop synchronizer for the asynchronous carrier plus a registered
// any-transition edge pulse.
module ask4_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 ^ s3;
    end
  end

endmodule

// File: rtl/ask4_demodulator.sv
// Recovers 2-bit symbols from the half-period of a 4-level carrier.
// Optional error statistics port/counter: define ASK4_DEMOD_STATS_EN.
module ask4_demodulator
  import ask4_pkg::*;
#(
  parameter int unsigned HP0     = HP0_DEF,
  parameter int unsigned HP1     = HP1_DEF,
  parameter int unsigned HP2     = HP2_DEF,
  parameter int unsigned HP3     = HP3_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned CONFIRM = CONFIRM_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       lock,
  output logic       err
`ifdef ASK4_DEMOD_STATS_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(HP3 + TOL + 1);
  localparam int unsigned      MW      = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

  logic             edge_p;
  logic [CNT_W-1:0] hp_cnt;
  logic             timeout;
  sym_t             cls;
  logic             cls_ok;
  state_t           state;
  sym_t             cand;
  logic [MW-1:0]    match;
  logic [MW-1:0]    match_nxt;
  logic             match_hit;

  ask4_edge_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (rx_in),
    .pulse (edge_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_cnt <= '0;
    end else if (edge_p) begin
      hp_cnt <= CNT_W'(1);
    end else if (hp_cnt != CNT_MAX) begin
      hp_cnt <= hp_cnt + CNT_W'(1);
    end
  end

  // hp_cnt passes TO_LIM only once per gap, so the timeout fires at most once.
  assign timeout = !edge_p && (hp_cnt == TO_LIM);

  always_comb begin
    cls    = '0;
    cls_ok = 1'b0;
    if (in_tol(32'(hp_cnt), HP0, TOL)) begin
      cls    = 2'd0;
      cls_ok = 1'b1;
    end else if (in_tol(32'(hp_cnt), HP1, TOL)) begin
      cls    = 2'd1;
      cls_ok = 1'b1;
    end else if (in_tol(32'(hp_cnt), HP2, TOL)) begin
      cls    = 2'd2;
      cls_ok = 1'b1;
    end else if (in_tol(32'(hp_cnt), HP3, TOL)) begin
      cls    = 2'd3;
      cls_ok = 1'b1;
    end
  end

  // A stale cand after arming is harmless: match is 0, so a hit still yields 1.
  always_comb begin
    match_nxt = (cls == cand) ? (match + MW'(1)) : MW'(1);
    match_hit = (match_nxt >= MW'(CONFIRM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      match     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      lock      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_p) begin
            state <= ACQ;
            match <= '0;
          end
        end
        ACQ: begin
          if (edge_p && cls_ok) begin
            cand  <= cls;
            match <= match_nxt;
            if (match_hit) begin
              state     <= LOCK;
              sym_out   <= cls;
              sym_valid <= 1'b1;
              lock      <= 1'b1;
            end
          end else if (edge_p || timeout) begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        LOCK: begin
          if (edge_p && cls_ok) begin
            if (cls != sym_out) begin
              cand  <= cls;
              match <= MW'(1);
              if (CONFIRM <= 1) begin
                sym_out   <= cls;
                sym_valid <= 1'b1;
              end else begin
                state <= ACQ;
                lock  <= 1'b0;
              end
            end
          end else if (edge_p || timeout) begin
            state <= IDLE;
            err   <= 1'b1;
            lock  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          lock  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASK4_DEMOD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ask4_demodulator.sv
// Scoreboard bench: a half-period level model predicts sym_valid/err events and
// their cycle; a negedge monitor pops and compares whenever the DUT emits one.
module tb_ask4_demodulator;

  localparam int CONFIRM = 3;
  localparam int TOL     = 1;
  localparam int TO_GAP  = 34;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       lock;
  logic       err;
`ifdef ASK4_DEMOD_STATS_EN
  logic [15:0] err_count;
`endif

  ask4_demodulator dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .lock      (lock),
    .err       (err)
`ifdef ASK4_DEMOD_STATS_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    bit         is_err;
    logic [1:0] sym;
    int         at;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // model: 0 = waiting for carrier, 1 = acquiring, 2 = locked
  int         m_state = 0;
  int         m_last  = 0;
  int         m_match = 0;
  int         m_cand  = 0;
  logic [1:0] m_sym   = 2'd0;
  int         m_errs  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nominal(input int k);
    return 4 << k;
  endfunction

  function automatic int classify(input int h);
    for (int k = 0; k < 4; k++)
      if (h >= nominal(k) - TOL && h <= nominal(k) + TOL) return k;
    return -1;
  endfunction

  task automatic push_ev(input bit is_err, input logic [1:0] s, input int at);
    ev_t e;
    e.is_err = is_err;
    e.sym    = s;
    e.at     = at;
    expq.push_back(e);
    if (is_err) m_errs++;
  endtask

  // Predicts the consequences of a carrier transition at cycle n.
  task automatic model_edge(input int n);
    int h, k;
    h = n - m_last;
    if (m_state == 0) begin
      m_state = 1;
      m_match = 0;
    end else if (h > TO_GAP) begin
      push_ev(1'b1, 2'd0, m_last + TO_GAP + 4);
      m_state = 1;
      m_match = 0;
    end else begin
      k = classify(h);
      if (k < 0) begin
        push_ev(1'b1, 2'd0, n + 4);
        m_state = 0;
      end else if (m_state == 1) begin
        if (m_match > 0 && k == m_cand) m_match++;
        else begin
          m_cand  = k;
          m_match = 1;
        end
        if (m_match >= CONFIRM) begin
          m_state = 2;
          m_sym   = 2'(m_cand);
          push_ev(1'b0, m_sym, n + 4);
        end
      end else if (2'(k) != m_sym) begin
        m_state = 1;
        m_cand  = k;
        m_match = 1;
      end
    end
    m_last = n;
  endtask

  // Waits h cycles and toggles rx_in; optionally checks the settled state of
  // the previous transition 5 cycles into the wait.
  task automatic tog(input int h, input bit chk);
    bit         exp_lock;
    logic [1:0] exp_sym;
    int         exp_errs;
    exp_lock = (m_state == 2);
    exp_sym  = m_sym;
    exp_errs = m_errs;
    model_edge(cyc + h);
    for (int i = 1; i <= h; i++) begin
      @(posedge clk);
      if (chk && i == 5) begin
        #1;
        checks++;
        if (lock !== exp_lock || sym_out !== exp_sym) begin
          errors++;
          $display("FAIL state@%0d: lock=%0b sym_out=%0d, required lock=%0b sym_out=%0d",
                   cyc, lock, sym_out, exp_lock, exp_sym);
        end
`ifdef ASK4_DEMOD_STATS_EN
        checks++;
        if (err_count !== 16'(exp_errs)) begin
          errors++;
          $display("FAIL err_count@%0d: got %0d, required %0d", cyc, err_count, exp_errs);
        end
`endif
      end
    end
    #1;
    rx_in = ~rx_in;
  endtask

  task automatic do_reset(input bit wiggle);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (wiggle) rx_in = ~rx_in;
    end
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_state = 0;
    m_errs  = 0;
    m_sym   = 2'd0;
    checks++;
    if (sym_out !== 2'd0 || sym_valid !== 1'b0 || lock !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: sym_out=%0d sym_valid=%0b lock=%0b err=%0b, required all 0",
               sym_out, sym_valid, lock, err);
    end
`ifdef ASK4_DEMOD_STATS_EN
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_err_count: got %0d, required 0", err_count);
    end
`endif
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (sym_valid || err)) begin
        checks++;
        if (sym_valid && err) begin
          errors++;
          $display("FAIL overlap@%0d: sym_valid=1 err=1, required never both", cyc);
        end else if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected@%0d: sym_valid=%0b err=%0b sym_out=%0d, required no event",
                   cyc, sym_valid, err, sym_out);
        end else begin
          e = expq.pop_front();
          if (e.is_err != err || e.at != cyc || (!e.is_err && e.sym !== sym_out) ||
              lock !== !e.is_err) begin
            errors++;
            $display("FAIL event@%0d: err=%0b sym_out=%0d lock=%0b, required err=%0b sym=%0d lock=%0b at cycle %0d",
                     cyc, err, sym_out, lock, e.is_err, e.sym, !e.is_err, e.at);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, k, h;
    rst   = 1'b1;
    rx_in = 1'b0;
    do_reset(1'b1);

    // Lock each symbol, then lose the carrier (timeout) during the long gap.
    for (int s = 0; s < 4; s++) begin
      tog(60, 1'b1);
      for (int i = 0; i < 5; i++) tog(nominal(s), 1'b0);
    end

    // Tolerance: 9 locks symbol 01, 6 is rejected.
    tog(60, 1'b1);
    for (int i = 0; i < 3; i++) tog(9, 1'b0);
    tog(6, 1'b1);

    // Symbol switch 00 -> 10.
    tog(60, 1'b1);
    for (int i = 0; i < 4; i++) tog(4, 1'b0);
    for (int i = 0; i < 3; i++) tog(16, 1'b1);
    tog(60, 1'b1);

    // Reset mid-acquisition discards the partial match.
    tog(8, 1'b0);
    do_reset(1'b0);
    tog(20, 1'b0);
    for (int i = 0; i < 3; i++) tog(8, 1'b1);

    // Random mix of nominal, edge-of-tolerance and arbitrary half-periods.
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        k = $urandom_range(0, 3);
        h = nominal(k) + $urandom_range(0, 2) - 1;
      end else begin
        h = $urandom_range(2, 40);
      end
      tog(h, h >= 5);
    end

    tog(60, 1'b1);
    if (m_state != 0) begin
      push_ev(1'b1, 2'd0, m_last + TO_GAP + 4);
      m_state = 0;
    end
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected events never appeared, required 0", expq.size());
    end
`ifdef ASK4_DEMOD_STATS_EN
    checks++;
    if (err_count !== 16'(m_errs)) begin
      errors++;
      $display("FAIL final_err_count: got %0d, required %0d", err_count, m_errs);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
